// File: rtl/i2s_tx.sv
// I2S transmitter: one 9-bit frame counter drives mclk/sclk/lrclk, and a 32-bit
// shift register serialises the stereo word captured once per frame (MSB first, one-bit delay).
module i2s_tx #(
    parameter int SAMPLE_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [SAMPLE_W-1:0] audio_l,
    input  logic [SAMPLE_W-1:0] audio_r,
    output logic                sample_tick,
    output logic                mclk,
    output logic                sclk,
    output logic                lrclk,
    output logic                sdin
);

    localparam int WORD_W = 2 * SAMPLE_W;

    logic [8:0]        c_reg;
    logic [WORD_W-1:0] shift_reg;
    logic              sdin_reg;
    logic              slot_end;
    logic              frame_end;

    assign slot_end  = (c_reg[3:0] == 4'hF);
    assign frame_end = (c_reg == 9'h1FF);

    // rst_n is active-high despite its name.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            c_reg     <= '0;
            shift_reg <= '0;
            sdin_reg  <= 1'b0;
        end else begin
            c_reg <= c_reg + 9'd1;
            if (slot_end) begin
                // After 31 left shifts the old R[0] sits in the MSB, so the
                // capture edge naturally emits it as slot 0 of the next frame.
                sdin_reg <= shift_reg[WORD_W-1];
                if (frame_end)
                    shift_reg <= en ? {audio_l, audio_r} : '0;
                else
                    shift_reg <= {shift_reg[WORD_W-2:0], 1'b0};
            end
        end
    end

    assign sample_tick = frame_end;
    assign mclk        = c_reg[1];
    assign sclk        = c_reg[3];
    assign lrclk       = c_reg[8];
    assign sdin        = sdin_reg;

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: tracks the frame position independently and
// compares the sampled sdin slots and clock outputs against hand-derived frames.
module tb_i2s_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] audio_l;
    logic [15:0] audio_r;
    logic        sample_tick;
    logic        mclk;
    logic        sclk;
    logic        lrclk;
    logic        sdin;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [8:0]  tc;
    logic [31:0] slots;
    logic [31:0] expv;
    int          clk_err;
    bit          chg_active;
    logic [15:0] chg_a;
    logic [15:0] chg_b;

    i2s_tx #(.SAMPLE_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .audio_l     (audio_l),
        .audio_r     (audio_r),
        .sample_tick (sample_tick),
        .mclk        (mclk),
        .sclk        (sclk),
        .lrclk       (lrclk),
        .sdin        (sdin)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        tc = tc + 9'd1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
        n_cmp++;
        assert (obs === exp_val) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_val);
        end
    endtask

    // Expected slot contents for a frame carrying {l,r}, slot 0 = prior R[0].
    function automatic logic [31:0] exp_frame(input logic r0, input logic [15:0] l, input logic [15:0] r);
        logic [31:0] e;
        e[0] = r0;
        for (int k = 1; k <= 16; k++) e[k] = l[16-k];
        for (int k = 17; k <= 31; k++) e[k] = r[32-k];
        return e;
    endfunction

    // Runs ncyc cycles, recording sdin at each sclk rising edge (slot mid-point)
    // and counting cycles where a clock output disagrees with the frame position.
    task automatic run_span(input int ncyc, output logic [31:0] sl, output int cerr);
        sl   = '0;
        cerr = 0;
        for (int i = 0; i < ncyc; i++) begin
            if (tc[3:0] == 4'd8) sl[tc[8:4]] = sdin;
            if (mclk !== tc[1] || sclk !== tc[3] || lrclk !== tc[8] ||
                sample_tick !== (tc == 9'd511))
                cerr++;
            if (chg_active && tc == 9'd100) audio_l = chg_a;
            if (chg_active && tc == 9'd300) audio_l = chg_b;
            step();
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_mclk"},  {31'd0, mclk},        32'd0);
        check({tag, "_sclk"},  {31'd0, sclk},        32'd0);
        check({tag, "_lrclk"}, {31'd0, lrclk},       32'd0);
        check({tag, "_tick"},  {31'd0, sample_tick}, 32'd0);
        check({tag, "_sdin"},  {31'd0, sdin},        32'd0);
    endtask

    initial begin
        rst_n      = 1'b1;
        en         = 1'b0;
        audio_l    = '0;
        audio_r    = '0;
        chg_active = 1'b0;
        chg_a      = '0;
        chg_b      = '0;
        tc         = '0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        tc = '0;
        check_reset_state("reset");
        rst_n = 1'b0;

        // Frame 1: all zeros regardless of inputs; capture A5F0/0F0F at its end.
        audio_l = 16'hA5F0;
        audio_r = 16'h0F0F;
        en      = 1'b1;
        run_span(512, slots, clk_err);
        check("f1_data", slots, 32'd0);
        check("f1_clocks", clk_err, 0);

        // Frame 2 carries A5F0/0F0F; audio_l changes mid-frame must not disturb it.
        chg_active = 1'b1;
        chg_a      = 16'h8001;
        chg_b      = 16'h7FFE;
        run_span(512, slots, clk_err);
        chg_active = 1'b0;
        expv = exp_frame(1'b0, 16'hA5F0, 16'h0F0F);
        check("f2_slot0", {31'd0, slots[0]}, 32'd0);
        check("f2_left",  {16'd0, slots[16:1]}, {16'd0, expv[16:1]});
        check("f2_right", {17'd0, slots[31:17]}, {17'd0, expv[31:17]});
        check("f2_clocks", clk_err, 0);

        // Frame 3: last write (7FFE) wins; slot 0 = R[0] of 0F0F = 1. Mute at its end.
        en      = 1'b0;
        audio_l = 16'hFFFF;
        audio_r = 16'hFFFF;
        run_span(512, slots, clk_err);
        check("f3_slot0", {31'd0, slots[0]}, 32'd1);
        check("f3_frame", slots, exp_frame(1'b1, 16'h7FFE, 16'h0F0F));
        check("f3_clocks", clk_err, 0);

        // Frame 4: muted, slot 0 keeps previous R[0] (0F0F -> 1).
        en      = 1'b1;
        audio_l = 16'h8000;
        audio_r = 16'h7FFF;
        run_span(512, slots, clk_err);
        check("f4_mute", slots, 32'h0000_0001);
        check("f4_clocks", clk_err, 0);

        // Frame 5: full-scale extremes, slot 0 from the muted word is 0.
        run_span(512, slots, clk_err);
        check("f5_extreme", slots, exp_frame(1'b0, 16'h8000, 16'h7FFF));
        check("f5_clocks", clk_err, 0);

        // Frame 6: run to c = 200 (slots 0..11 sampled), then reset mid-frame.
        run_span(200, slots, clk_err);
        expv = exp_frame(1'b1, 16'h8000, 16'h7FFF);
        check("f6_partial", {20'd0, slots[11:0]}, {20'd0, expv[11:0]});
        check("f6_clocks", clk_err, 0);
        rst_n = 1'b1;
        step();
        tc = '0;
        check_reset_state("midreset");
        rst_n = 1'b0;

        // Frame after reset is all zeros; the one after carries 8000/7FFF.
        run_span(512, slots, clk_err);
        check("f7_zero", slots, 32'd0);
        check("f7_clocks", clk_err, 0);
        run_span(512, slots, clk_err);
        check("f8_extreme", slots, exp_frame(1'b0, 16'h8000, 16'h7FFF));
        check("f8_clocks", clk_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
